sata_rx_prim_dec: RTL and testbench

SATA_RX_PRIM_DEC -- requirements
Module: sata_rx_prim_dec

---
 rtl/sata_prim_pkg.sv | 63 ++++++
 rtl/sata_rx_prim_dec_if.sv | 27 ++
 rtl/sata_prim_lookup.sv | 37 +++
 rtl/sata_rx_prim_dec.sv | 127 ++++++++++++
 tb/tb_sata_rx_prim_dec.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/sata_prim_pkg.sv
// Shared SATA primitive definitions: dword constants, prim_code values and
// receive-decoder state encodings. The TX primitive generator uses the same package.
package sata_prim_pkg;

    localparam logic [31:0] DW_ALIGN   = 32'h7B4A_4ABC;
    localparam logic [31:0] DW_SYNC    = 32'hB5B5_957C;
    localparam logic [31:0] DW_X_RDY   = 32'h5757_B57C;
    localparam logic [31:0] DW_R_RDY   = 32'h4A4A_957C;
    localparam logic [31:0] DW_SOF     = 32'h3737_B57C;
    localparam logic [31:0] DW_EOF     = 32'hD5D5_B57C;
    localparam logic [31:0] DW_HOLD    = 32'hD5D5_AA7C;
    localparam logic [31:0] DW_HOLDA   = 32'h9595_AA7C;
    localparam logic [31:0] DW_CONT    = 32'h9999_AA7C;
    localparam logic [31:0] DW_R_IP    = 32'h5555_B57C;
    localparam logic [31:0] DW_R_OK    = 32'h3535_B57C;
    localparam logic [31:0] DW_R_ERR   = 32'h5656_B57C;
    localparam logic [31:0] DW_WTRM    = 32'h5858_B57C;
    localparam logic [31:0] DW_DMAT    = 32'h3636_B57C;
    localparam logic [31:0] DW_PMREQ_P = 32'h1717_B57C;
    localparam logic [31:0] DW_PMREQ_S = 32'h7575_957C;
    localparam logic [31:0] DW_PMACK   = 32'h9595_957C;
    localparam logic [31:0] DW_PMNAK   = 32'hF5F5_957C;

    typedef enum logic [4:0] {
        PRIM_NONE    = 5'd0,
        PRIM_ALIGN   = 5'd1,
        PRIM_SYNC    = 5'd2,
        PRIM_X_RDY   = 5'd3,
        PRIM_R_RDY   = 5'd4,
        PRIM_SOF     = 5'd5,
        PRIM_EOF     = 5'd6,
        PRIM_HOLD    = 5'd7,
        PRIM_HOLDA   = 5'd8,
        PRIM_CONT    = 5'd9,
        PRIM_R_IP    = 5'd10,
        PRIM_R_OK    = 5'd11,
        PRIM_R_ERR   = 5'd12,
        PRIM_WTRM    = 5'd13,
        PRIM_DMAT    = 5'd14,
        PRIM_PMREQ_P = 5'd15,
        PRIM_PMREQ_S = 5'd16,
        PRIM_PMACK   = 5'd17,
        PRIM_PMNAK   = 5'd18,
        PRIM_UNKNOWN = 5'd31
    } prim_code_e;

    typedef enum logic [1:0] {
        ST_LINK_DOWN   = 2'd0,
        ST_NORMAL      = 2'd1,
        ST_CONT_ACTIVE = 2'd2
    } dec_state_e;

    // Primitives a CONT may stand in for; framing markers and unknowns may not.
    function automatic logic prim_repeatable(input prim_code_e c);
        case (c)
            PRIM_SYNC, PRIM_X_RDY, PRIM_R_RDY, PRIM_HOLD, PRIM_HOLDA,
            PRIM_R_IP, PRIM_R_OK, PRIM_R_ERR, PRIM_WTRM, PRIM_DMAT,
            PRIM_PMREQ_P, PRIM_PMREQ_S, PRIM_PMACK, PRIM_PMNAK: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sata_rx_prim_dec_if.sv
// Phy-side receive bus into the primitive decoder and its decoded outputs.
interface sata_rx_prim_dec_if
    import sata_prim_pkg::*;
#(
    parameter int C_ERRCNT_W = 16
);
    logic [31:0]           rxdata;
    logic                  rxdatak;
    logic                  link_up;
    logic                  prim_valid;
    prim_code_e            prim_code;
    logic                  data_valid;
    logic [31:0]           data_out;
    logic                  in_frame;
    logic                  dec_err;
    logic [C_ERRCNT_W-1:0] err_cnt;

    modport master (
        output rxdata, rxdatak, link_up,
        input  prim_valid, prim_code, data_valid, data_out, in_frame, dec_err, err_cnt
    );

    modport slave (
        input  rxdata, rxdatak, link_up,
        output prim_valid, prim_code, data_valid, data_out, in_frame, dec_err, err_cnt
    );
endinterface

// File: rtl/sata_prim_lookup.sv
// Combinational dword-to-primitive lookup; non-K dwords map to PRIM_NONE.
module sata_prim_lookup
    import sata_prim_pkg::*;
(
    input  logic [31:0] i_dword,
    input  logic        i_k,
    output prim_code_e  o_code
);

    always_comb begin
        o_code = PRIM_NONE;
        if (i_k) begin
            case (i_dword)
                DW_ALIGN:   o_code = PRIM_ALIGN;
                DW_SYNC:    o_code = PRIM_SYNC;
                DW_X_RDY:   o_code = PRIM_X_RDY;
                DW_R_RDY:   o_code = PRIM_R_RDY;
                DW_SOF:     o_code = PRIM_SOF;
                DW_EOF:     o_code = PRIM_EOF;
                DW_HOLD:    o_code = PRIM_HOLD;
                DW_HOLDA:   o_code = PRIM_HOLDA;
                DW_CONT:    o_code = PRIM_CONT;
                DW_R_IP:    o_code = PRIM_R_IP;
                DW_R_OK:    o_code = PRIM_R_OK;
                DW_R_ERR:   o_code = PRIM_R_ERR;
                DW_WTRM:    o_code = PRIM_WTRM;
                DW_DMAT:    o_code = PRIM_DMAT;
                DW_PMREQ_P: o_code = PRIM_PMREQ_P;
                DW_PMREQ_S: o_code = PRIM_PMREQ_S;
                DW_PMACK:   o_code = PRIM_PMACK;
                DW_PMNAK:   o_code = PRIM_PMNAK;
                default:    o_code = PRIM_UNKNOWN;
            endcase
        end
    end

endmodule

// File: rtl/sata_rx_prim_dec.sv
// SATA receive primitive decoder: CONT expansion, frame tracking, error counting.
//   state          | meaning
//   ST_LINK_DOWN   | link not up, outputs held at zero
//   ST_NORMAL      | primitives reported as received, frame payload passed
//   ST_CONT_ACTIVE | last primitive repeated every cycle, scrambled filler ignored
module sata_rx_prim_dec
    import sata_prim_pkg::*;
#(
    parameter int C_ERRCNT_W = 16
)(
    input logic              clk_75m,
    input logic              host_rst_n,
    sata_rx_prim_dec_if.slave rx
);

    prim_code_e            w_code;
    logic                  w_is_prim;
    dec_state_e            r_state, w_state_nxt;
    prim_code_e            r_last_prim, w_last_nxt;
    prim_code_e            r_prim_code, w_prim_code_nxt;
    logic                  r_in_frame, w_in_frame_nxt;
    logic                  r_prim_valid, w_prim_valid_nxt;
    logic                  r_data_valid, w_data_valid_nxt;
    logic                  r_dec_err, w_dec_err_nxt;
    logic [31:0]           r_data_out, w_data_out_nxt;
    logic [C_ERRCNT_W-1:0] r_err_cnt;

    sata_prim_lookup u_lookup (
        .i_dword (rx.rxdata),
        .i_k     (rx.rxdatak),
        .o_code  (w_code)
    );

    assign w_is_prim = (w_code != PRIM_NONE) && (w_code != PRIM_ALIGN) && (w_code != PRIM_CONT);

    always_comb begin
        w_state_nxt      = r_state;
        w_last_nxt       = r_last_prim;
        w_in_frame_nxt   = r_in_frame;
        w_prim_valid_nxt = 1'b0;
        w_prim_code_nxt  = PRIM_NONE;
        w_data_valid_nxt = 1'b0;
        w_data_out_nxt   = '0;
        w_dec_err_nxt    = 1'b0;
        if (!rx.link_up) begin
            w_state_nxt    = ST_LINK_DOWN;
            w_in_frame_nxt = 1'b0;
            w_last_nxt     = PRIM_NONE;
        end else begin
            case (r_state)
                ST_LINK_DOWN: w_state_nxt = ST_NORMAL;
                ST_NORMAL, ST_CONT_ACTIVE: begin
                    if (w_is_prim) begin
                        w_state_nxt      = ST_NORMAL;
                        w_prim_valid_nxt = 1'b1;
                        w_prim_code_nxt  = w_code;
                        w_last_nxt       = w_code;
                        case (w_code)
                            PRIM_SOF: begin
                                w_in_frame_nxt = 1'b1;
                                w_dec_err_nxt  = r_in_frame;
                            end
                            PRIM_EOF, PRIM_WTRM, PRIM_SYNC: w_in_frame_nxt = 1'b0;
                            PRIM_UNKNOWN: w_dec_err_nxt = 1'b1;
                            default: ;
                        endcase
                    end else if (r_state == ST_CONT_ACTIVE) begin
                        if (w_code != PRIM_ALIGN) begin
                            w_prim_valid_nxt = 1'b1;
                            w_prim_code_nxt  = r_last_prim;
                        end
                    end else if (w_code == PRIM_CONT) begin
                        if (prim_repeatable(r_last_prim)) begin
                            w_state_nxt      = ST_CONT_ACTIVE;
                            w_prim_valid_nxt = 1'b1;
                            w_prim_code_nxt  = r_last_prim;
                        end else begin
                            w_dec_err_nxt = 1'b1;
                        end
                    end else if (w_code == PRIM_NONE) begin
                        if (r_in_frame) begin
                            w_data_valid_nxt = 1'b1;
                            w_data_out_nxt   = rx.rxdata;
                        end else begin
                            w_dec_err_nxt = 1'b1;
                        end
                    end
                end
                default: w_state_nxt = ST_LINK_DOWN;
            endcase
        end
    end

    always_ff @(posedge clk_75m) begin
        if (!host_rst_n) begin
            r_state      <= ST_LINK_DOWN;
            r_last_prim  <= PRIM_NONE;
            r_prim_code  <= PRIM_NONE;
            r_in_frame   <= 1'b0;
            r_prim_valid <= 1'b0;
            r_data_valid <= 1'b0;
            r_dec_err    <= 1'b0;
            r_data_out   <= '0;
            r_err_cnt    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_prim  <= w_last_nxt;
            r_prim_code  <= w_prim_code_nxt;
            r_in_frame   <= w_in_frame_nxt;
            r_prim_valid <= w_prim_valid_nxt;
            r_data_valid <= w_data_valid_nxt;
            r_dec_err    <= w_dec_err_nxt;
            r_data_out   <= w_data_out_nxt;
            if (w_dec_err_nxt && (r_err_cnt != '1))
                r_err_cnt <= r_err_cnt + {{(C_ERRCNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign rx.prim_valid = r_prim_valid;
    assign rx.prim_code  = r_prim_code;
    assign rx.data_valid = r_data_valid;
    assign rx.data_out   = r_data_out;
    assign rx.in_frame   = r_in_frame;
    assign rx.dec_err    = r_dec_err;
    assign rx.err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_sata_rx_prim_dec.sv
// Directed bench for sata_rx_prim_dec; a narrow error counter makes saturation reachable.
module tb_sata_rx_prim_dec;
    import sata_prim_pkg::*;

    typedef struct packed {
        logic        pv;
        logic [4:0]  code;
        logic        dv;
        logic [31:0] data;
        logic        inf;
        logic        err;
        logic [3:0]  cnt;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n;
    obs_t       exp_q[$];
    string      tag_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [3:0] m_cnt = 4'd0;
    logic [31:0] tbl_dw[10];
    logic [4:0]  tbl_c[10];

    sata_rx_prim_dec_if #(.C_ERRCNT_W(4)) bus ();

    sata_rx_prim_dec #(.C_ERRCNT_W(4)) dut (
        .clk_75m    (clk),
        .host_rst_n (rst_n),
        .rx         (bus)
    );

    always #5 clk = ~clk;

    task automatic step(input logic rst, input logic lk, input logic k, input logic [31:0] d,
                        input logic pv, input logic [4:0] code, input logic dv, input logic [31:0] dout,
                        input logic inf, input logic err, input string tag);
        obs_t o, e;
        string t;
        rst_n       = rst;
        bus.link_up = lk;
        bus.rxdatak = k;
        bus.rxdata  = d;
        if (!rst)
            m_cnt = 4'd0;
        else if (err && m_cnt != 4'hF)
            m_cnt = m_cnt + 4'd1;
        exp_q.push_back('{pv, code, dv, dout, inf, err, m_cnt});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        o = '{bus.prim_valid, bus.prim_code, bus.data_valid, bus.data_out,
              bus.in_frame, bus.dec_err, bus.err_cnt};
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", t, o, e);
        end
    endtask

    // K primitive on a live link, reset released
    task automatic kp(input logic [31:0] d, input logic pv, input logic [4:0] code,
                      input logic inf, input logic err, input string tag);
        step(1'b1, 1'b1, 1'b1, d, pv, code, 1'b0, 32'h0, inf, err, tag);
    endtask

    task automatic nk(input logic [31:0] d, input logic pv, input logic [4:0] code, input logic dv,
                      input logic inf, input logic err, input string tag);
        step(1'b1, 1'b1, 1'b0, d, pv, code, dv, dv ? d : 32'h0, inf, err, tag);
    endtask

    initial begin
        tbl_dw = '{DW_R_IP, DW_R_ERR, DW_DMAT, DW_PMREQ_P, DW_PMREQ_S,
                   DW_PMACK, DW_PMNAK, DW_HOLDA, DW_X_RDY, DW_R_RDY};
        tbl_c  = '{PRIM_R_IP, PRIM_R_ERR, PRIM_DMAT, PRIM_PMREQ_P, PRIM_PMREQ_S,
                   PRIM_PMACK, PRIM_PMNAK, PRIM_HOLDA, PRIM_X_RDY, PRIM_R_RDY};
        rst_n = 1'b0;
        bus.link_up = 1'b0;
        bus.rxdatak = 1'b0;
        bus.rxdata  = 32'h0;

        step(1'b0, 1'b0, 1'b1, DW_SYNC, 0, PRIM_NONE, 0, 0, 0, 0, "reset");
        step(1'b1, 1'b0, 1'b0, 32'hCAFE0000, 0, PRIM_NONE, 0, 0, 0, 0, "link_down_idle");
        kp(DW_SYNC, 0, PRIM_NONE, 0, 0, "link_up_transition");

        kp(DW_SYNC,  1, PRIM_SYNC, 0, 0, "sync");
        kp(DW_CONT,  1, PRIM_SYNC, 0, 0, "cont_sync");
        nk(32'h12345678, 1, PRIM_SYNC, 0, 0, 0, "cont_filler1");
        nk(32'hDEADBEEF, 1, PRIM_SYNC, 0, 0, 0, "cont_filler2");
        kp(DW_ALIGN, 0, PRIM_NONE, 0, 0, "align_in_cont");
        kp(DW_X_RDY, 1, PRIM_X_RDY, 0, 0, "x_rdy_exit_cont");

        kp(DW_SOF, 1, PRIM_SOF, 1, 0, "sof");
        nk(32'h00000001, 0, PRIM_NONE, 1, 1, 0, "data1");
        nk(32'h00000002, 0, PRIM_NONE, 1, 1, 0, "data2");
        kp(DW_HOLD, 1, PRIM_HOLD, 1, 0, "hold");
        kp(DW_CONT, 1, PRIM_HOLD, 1, 0, "cont_hold");
        nk(32'hAAAAAAAA, 1, PRIM_HOLD, 0, 1, 0, "hold_filler1");
        nk(32'h00000003, 1, PRIM_HOLD, 0, 1, 0, "hold_filler2");
        kp(DW_EOF, 1, PRIM_EOF, 0, 0, "eof");

        kp(DW_SOF,  1, PRIM_SOF, 1, 0, "sof2");
        kp(DW_ALIGN, 0, PRIM_NONE, 1, 0, "align_in_frame");
        kp(DW_SOF,  1, PRIM_SOF, 1, 1, "sof_restart");
        kp(DW_WTRM, 1, PRIM_WTRM, 0, 0, "wtrm_closes");
        kp(DW_CONT, 1, PRIM_WTRM, 0, 0, "cont_wtrm");
        kp(DW_R_OK, 1, PRIM_R_OK, 0, 0, "r_ok_exit_cont");
        kp(DW_EOF,  1, PRIM_EOF, 0, 0, "eof_no_frame");
        kp(DW_CONT, 0, PRIM_NONE, 0, 1, "cont_after_eof");

        step(1'b0, 1'b1, 1'b1, DW_SYNC, 0, PRIM_NONE, 0, 0, 0, 0, "reset2");
        kp(DW_SYNC, 0, PRIM_NONE, 0, 0, "link_up_transition2");
        kp(DW_CONT, 0, PRIM_NONE, 0, 1, "cont_no_last");
        nk(32'h11111111, 0, PRIM_NONE, 0, 0, 1, "data_out_of_frame");

        kp(32'h0000007C, 1, PRIM_UNKNOWN, 0, 1, "unknown_k");
        kp(DW_CONT, 0, PRIM_NONE, 0, 1, "cont_after_unknown");
        for (int i = 0; i < 12; i++)
            kp(32'h0000007C, 1, PRIM_UNKNOWN, 0, 1, "unknown_saturate");
        nk(32'h0BADF00D, 0, PRIM_NONE, 0, 0, 1, "saturated_hold");

        kp(DW_SOF, 1, PRIM_SOF, 1, 0, "sof3");
        nk(32'h5A5A5A5A, 0, PRIM_NONE, 1, 1, 0, "data_mid_frame");
        step(1'b1, 1'b0, 1'b0, 32'h77777777, 0, PRIM_NONE, 0, 0, 0, 0, "link_drop");
        kp(DW_SYNC, 0, PRIM_NONE, 0, 0, "link_restore");
        nk(32'h00000005, 0, PRIM_NONE, 0, 0, 1, "data_after_relink");

        kp(DW_HOLDA, 1, PRIM_HOLDA, 0, 0, "holda");
        kp(DW_CONT,  1, PRIM_HOLDA, 0, 0, "cont_holda");
        nk(32'h13572468, 1, PRIM_HOLDA, 0, 0, 0, "holda_filler");
        step(1'b0, 1'b1, 1'b0, 32'h24681357, 0, PRIM_NONE, 0, 0, 0, 0, "reset_in_cont");
        kp(DW_R_RDY, 0, PRIM_NONE, 0, 0, "link_up_transition3");

        kp(DW_R_RDY, 1, PRIM_R_RDY, 0, 0, "r_rdy");
        kp(DW_ALIGN, 0, PRIM_NONE, 0, 0, "align_normal");
        kp(DW_CONT,  1, PRIM_R_RDY, 0, 0, "cont_keeps_last_over_align");
        for (int i = 0; i < 10; i++)
            kp(tbl_dw[i], 1, tbl_c[i], 0, 0, "lookup_table");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
